rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 156 +++++++++++++++
 tb/tb_rom_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Arbitrates main- and sound-CPU ROM reads onto one shared memory port (round-robin on ties).
// Optional ack timeout is built only when the ROM_ARB_TMO_EN macro is defined.
module rom_arbiter #(
  parameter logic [23:0] SND_BASE   = 24'h080000,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_rom_cs,
  input  logic        p_as_n,
  input  logic [18:0] p_addr,
  input  logic        s_rom_cs,
  input  logic        s_as_n,
  input  logic [15:0] s_addr,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [15:0] p_dout,
  output logic [15:0] s_dout,
  output logic        p_dtack_n,
  output logic        s_dtack_n,
  output logic        tmo_err
);

  typedef enum logic [2:0] {IDLE, P_BUSY, S_BUSY, P_HOLD, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic        p_served_q, p_served_d;
  logic        s_served_q, s_served_d;
  logic        last_s_q, last_s_d;
  logic        abort_q, abort_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [15:0] p_dout_q, p_dout_d;
  logic [15:0] s_dout_q, s_dout_d;

  logic p_pend, s_pend, grant_p, grant_s;
  logic busy, cur_as_n, aborted, done, tmo_hit;

  assign p_pend   = p_rom_cs & ~p_as_n & ~p_served_q;
  assign s_pend   = s_rom_cs & ~s_as_n & ~s_served_q;
  assign busy     = (state_q == P_BUSY) || (state_q == S_BUSY);
  assign cur_as_n = (state_q == P_BUSY) ? p_as_n : s_as_n;
  // Once the granted CPU drops its strobe, the bus cycle is abandoned even if it re-strobes.
  assign aborted  = abort_q | cur_as_n;
  assign done     = busy & (mem_ack | tmo_hit);
  assign grant_p  = (state_q == IDLE) & p_pend & (~s_pend | last_s_q);
  assign grant_s  = (state_q == IDLE) & s_pend & ~grant_p;

`ifdef ROM_ARB_TMO_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_err_q, tmo_err_d;

  assign tmo_hit   = busy & ~mem_ack & (tmo_cnt_q == 8'(TMO_CYCLES - 1));
  assign tmo_cnt_d = (busy & ~done) ? tmo_cnt_q + 8'd1 : 8'd0;
  assign tmo_err_d = tmo_hit;
  assign tmo_err   = tmo_err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_q <= 8'd0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_p)      state_d = P_BUSY;
        else if (grant_s) state_d = S_BUSY;
      end
      P_BUSY: if (done) state_d = aborted ? IDLE : P_HOLD;
      S_BUSY: if (done) state_d = aborted ? IDLE : S_HOLD;
      P_HOLD: if (p_as_n) state_d = IDLE;
      S_HOLD: if (s_as_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_req   = busy;
    p_dtack_n = (state_q != P_HOLD);
    s_dtack_n = (state_q != S_HOLD);
  end

  assign mem_addr = mem_addr_q;
  assign p_dout   = p_dout_q;
  assign s_dout   = s_dout_q;

  // Datapath and bookkeeping next-state
  always_comb begin
    p_served_d = p_served_q;
    s_served_d = s_served_q;
    last_s_d   = last_s_q;
    abort_d    = busy & ~done & aborted;
    mem_addr_d = mem_addr_q;
    p_dout_d   = p_dout_q;
    s_dout_d   = s_dout_q;

    if (grant_p)      mem_addr_d = {4'h0, p_addr, 1'b0};
    else if (grant_s) mem_addr_d = SND_BASE + {7'h0, s_addr, 1'b0};

    if (done) begin
      last_s_d = (state_q == S_BUSY);
      if (state_q == P_BUSY) begin
        p_dout_d = mem_ack ? mem_data : 16'hFFFF;
        if (!aborted) p_served_d = 1'b1;
      end else begin
        s_dout_d = mem_ack ? mem_data : 16'hFFFF;
        if (!aborted) s_served_d = 1'b1;
      end
    end

    if (p_as_n) p_served_d = 1'b0;
    if (s_as_n) s_served_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_served_q <= 1'b0;
      s_served_q <= 1'b0;
      last_s_q   <= 1'b1;
      abort_q    <= 1'b0;
      mem_addr_q <= 24'h0;
      p_dout_q   <= 16'h0;
      s_dout_q   <= 16'h0;
    end else begin
      p_served_q <= p_served_d;
      s_served_q <= s_served_d;
      last_s_q   <= last_s_d;
      abort_q    <= abort_d;
      mem_addr_q <= mem_addr_d;
      p_dout_q   <= p_dout_d;
      s_dout_q   <= s_dout_d;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter; timeout scenario follows ROM_ARB_TMO_EN.
module tb_rom_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        p_rom_cs, p_as_n, s_rom_cs, s_as_n;
  logic [18:0] p_addr;
  logic [15:0] s_addr;
  logic        mem_req, mem_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_data, p_dout, s_dout;
  logic        p_dtack_n, s_dtack_n, tmo_err;

  int checks   = 0;
  int failures = 0;

  rom_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .p_rom_cs(p_rom_cs), .p_as_n(p_as_n), .p_addr(p_addr),
    .s_rom_cs(s_rom_cs), .s_as_n(s_as_n), .s_addr(s_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .p_dout(p_dout), .s_dout(s_dout), .p_dtack_n(p_dtack_n), .s_dtack_n(s_dtack_n),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [15:0] d);
    mem_ack = 1'b1; mem_data = d;
    tick();
    mem_ack = 1'b0; mem_data = 16'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", mem_req); end
    checks++; if (mem_addr !== 24'h0) begin failures++; $display("FAIL rst_addr got=%06h exp=000000", mem_addr); end
    checks++; if (p_dout !== 16'h0 || s_dout !== 16'h0) begin failures++; $display("FAIL rst_dout got=%04h/%04h exp=0000/0000", p_dout, s_dout); end
    checks++; if (p_dtack_n !== 1'b1 || s_dtack_n !== 1'b1) begin failures++; $display("FAIL rst_dtack got=%b%b exp=11", p_dtack_n, s_dtack_n); end
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL rst_tmo got=%0h exp=0", tmo_err); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_main_read();
    p_rom_cs = 1'b1; p_as_n = 1'b0; p_addr = 19'h00010;
    tick();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL main_req got=%0h exp=1", mem_req); end
    checks++; if (mem_addr !== 24'h000020) begin failures++; $display("FAIL main_addr got=%06h exp=000020", mem_addr); end
    tick(); tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h000020 || p_dtack_n !== 1'b1) begin failures++; $display("FAIL main_wait got=%0h/%06h/%0h exp=1/000020/1", mem_req, mem_addr, p_dtack_n); end
    ack(16'h4E71);
    checks++; if (p_dtack_n !== 1'b0) begin failures++; $display("FAIL main_dtack got=%0h exp=0", p_dtack_n); end
    checks++; if (p_dout !== 16'h4E71) begin failures++; $display("FAIL main_dout got=%04h exp=4e71", p_dout); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL main_req_drop got=%0h exp=0", mem_req); end
    ack(16'hDEAD);  // stray ack during HOLD
    checks++; if (p_dout !== 16'h4E71 || p_dtack_n !== 1'b0) begin failures++; $display("FAIL hold_ack_ign got=%04h/%0h exp=4e71/0", p_dout, p_dtack_n); end
    p_as_n = 1'b1; p_rom_cs = 1'b0;
    tick();
    checks++; if (p_dtack_n !== 1'b1) begin failures++; $display("FAIL main_release got=%0h exp=1", p_dtack_n); end
  endtask

  task automatic test_sound_read();
    s_rom_cs = 1'b1; s_as_n = 1'b0; s_addr = 16'h0004;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h080008) begin failures++; $display("FAIL snd_addr got=%0h/%06h exp=1/080008", mem_req, mem_addr); end
    tick();
    ack(16'hBEEF);
    checks++; if (s_dtack_n !== 1'b0 || s_dout !== 16'hBEEF) begin failures++; $display("FAIL snd_done got=%0h/%04h exp=0/beef", s_dtack_n, s_dout); end
    checks++; if (p_dtack_n !== 1'b1 || p_dout !== 16'h4E71) begin failures++; $display("FAIL snd_p_hold got=%0h/%04h exp=1/4e71", p_dtack_n, p_dout); end
    s_as_n = 1'b1; s_rom_cs = 1'b0;
    tick();
    checks++; if (s_dtack_n !== 1'b1) begin failures++; $display("FAIL snd_release got=%0h exp=1", s_dtack_n); end
  endtask

  task automatic test_tie();
    test_reset();
    p_rom_cs = 1'b1; p_as_n = 1'b0; p_addr = 19'h00100;
    s_rom_cs = 1'b1; s_as_n = 1'b0; s_addr = 16'h0010;
    tick();
    checks++; if (mem_addr !== 24'h000200) begin failures++; $display("FAIL tie1_main_first got=%06h exp=000200", mem_addr); end
    ack(16'h1111);
    checks++; if (p_dtack_n !== 1'b0 || s_dtack_n !== 1'b1) begin failures++; $display("FAIL tie1_dtack got=%b%b exp=01", p_dtack_n, s_dtack_n); end
    p_as_n = 1'b1;
    tick();
    p_as_n = 1'b0; p_addr = 19'h00200;  // main re-requests: tie again
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h080020) begin failures++; $display("FAIL tie2_sound_first got=%0h/%06h exp=1/080020", mem_req, mem_addr); end
    ack(16'h3333);
    checks++; if (s_dtack_n !== 1'b0 || s_dout !== 16'h3333 || p_dtack_n !== 1'b1) begin failures++; $display("FAIL tie2_snd got=%0h/%04h/%0h exp=0/3333/1", s_dtack_n, s_dout, p_dtack_n); end
    s_as_n = 1'b1; s_rom_cs = 1'b0;
    tick(); tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h000400) begin failures++; $display("FAIL tie2_main_next got=%0h/%06h exp=1/000400", mem_req, mem_addr); end
    ack(16'h4444);
    checks++; if (p_dout !== 16'h4444 || p_dtack_n !== 1'b0) begin failures++; $display("FAIL tie2_main_done got=%04h/%0h exp=4444/0", p_dout, p_dtack_n); end
    p_as_n = 1'b1; p_rom_cs = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    p_rom_cs = 1'b1; p_as_n = 1'b0; p_addr = 19'h00300;
    tick();
    s_rom_cs = 1'b1; s_as_n = 1'b0; s_addr = 16'h0020;
    p_as_n = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h000600 || p_dtack_n !== 1'b1) begin failures++; $display("FAIL abort_busy got=%0h/%06h/%0h exp=1/000600/1", mem_req, mem_addr, p_dtack_n); end
    ack(16'h5555);
    checks++; if (p_dtack_n !== 1'b1 || mem_req !== 1'b0 || p_dout !== 16'h5555) begin failures++; $display("FAIL abort_idle got=%0h/%0h/%04h exp=1/0/5555", p_dtack_n, mem_req, p_dout); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h080040) begin failures++; $display("FAIL abort_snd_next got=%0h/%06h exp=1/080040", mem_req, mem_addr); end
    ack(16'h6666);
    checks++; if (s_dtack_n !== 1'b0 || s_dout !== 16'h6666) begin failures++; $display("FAIL abort_snd_done got=%0h/%04h exp=0/6666", s_dtack_n, s_dout); end
    s_as_n = 1'b1; s_rom_cs = 1'b0; p_rom_cs = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    s_rom_cs = 1'b1; s_as_n = 1'b0; s_addr = 16'h0030;
    tick();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rmid_busy got=%0h exp=1", mem_req); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; s_as_n = 1'b1; s_rom_cs = 1'b0;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 24'h0 || s_dout !== 16'h0 || p_dout !== 16'h0) begin failures++; $display("FAIL rmid_outs got=%0h/%06h/%04h/%04h exp=0/000000/0000/0000", mem_req, mem_addr, s_dout, p_dout); end
    checks++; if (p_dtack_n !== 1'b1 || s_dtack_n !== 1'b1 || tmo_err !== 1'b0) begin failures++; $display("FAIL rmid_flags got=%b%b%b exp=110", p_dtack_n, s_dtack_n, tmo_err); end
    ack(16'h7777);
    checks++; if (mem_req !== 1'b0 || s_dout !== 16'h0 || s_dtack_n !== 1'b1) begin failures++; $display("FAIL rmid_stray got=%0h/%04h/%0h exp=0/0000/1", mem_req, s_dout, s_dtack_n); end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    p_rom_cs = 1'b1; p_as_n = 1'b0; p_addr = 19'h00400;
    tick();
`ifdef ROM_ARB_TMO_EN
    for (int i = 0; i < 254; i++) begin
      tick();
      if (tmo_err !== 1'b0 || mem_req !== 1'b1) early++;
    end
    checks++; if (early != 0) begin failures++; $display("FAIL tmo_early got=%0d exp=0", early); end
    tick();
    checks++; if (tmo_err !== 1'b1 || p_dout !== 16'hFFFF || p_dtack_n !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL tmo_fire got=%0h/%04h/%0h/%0h exp=1/ffff/0/0", tmo_err, p_dout, p_dtack_n, mem_req); end
    tick();
    checks++; if (tmo_err !== 1'b0 || p_dtack_n !== 1'b0) begin failures++; $display("FAIL tmo_pulse got=%0h/%0h exp=0/0", tmo_err, p_dtack_n); end
`else
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tmo_err !== 1'b0 || mem_req !== 1'b1) early++;
    end
    checks++; if (early != 0) begin failures++; $display("FAIL notmo_wait got=%0d exp=0", early); end
    ack(16'h9999);
    checks++; if (p_dout !== 16'h9999 || p_dtack_n !== 1'b0) begin failures++; $display("FAIL notmo_ack got=%04h/%0h exp=9999/0", p_dout, p_dtack_n); end
`endif
    p_as_n = 1'b1; p_rom_cs = 1'b0;
    tick();
    checks++; if (p_dtack_n !== 1'b1) begin failures++; $display("FAIL tmo_release got=%0h exp=1", p_dtack_n); end
  endtask

  initial begin
    reset_n = 1'b0; mem_ack = 1'b0; mem_data = 16'h0;
    p_rom_cs = 1'b0; p_as_n = 1'b1; p_addr = 19'h0;
    s_rom_cs = 1'b0; s_as_n = 1'b1; s_addr = 16'h0;
    #2;
    test_reset();
    test_main_read();
    test_sound_read();
    test_tie();
    test_abort();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
